// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg: round counts, direction encodings and sequencer state encoding. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  localparam logic AES_DIR_ENC = 1'b0;
  localparam logic AES_DIR_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // The reserved key-length code falls back to the AES-128 round count.
  function automatic int nr_for_keylen(input logic [1:0] keylen);
    case (keylen)
      2'b01:   nr_for_keylen = AES_NR_192;
      2'b10:   nr_for_keylen = AES_NR_256;
      default: nr_for_keylen = AES_NR_128;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_keylen_nr.sv
// ----------------------------------------------------------------------------
// aes_keylen_nr: combinational KeyLen -> Nr decode, shared with key expansion. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module aes_keylen_nr
  import aes_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [1:0]    keylen,
  output logic [CW-1:0] nr
);

  assign nr = CW'(nr_for_keylen(keylen));

endmodule

`default_nettype wire

// File: rtl/aes_round_sequencer.sv
// ----------------------------------------------------------------------------
// aes_round_sequencer: up/down AES round counter with First/Last/Busy/Done strobes.
// Optional per-block key length selection under AES_ROUND_SEQ_KEYLEN_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int CW = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Clr,
  input  logic          Start,
  input  logic          Dir,
`ifdef AES_ROUND_SEQ_KEYLEN_EN
  input  logic [1:0]    KeyLen,
`endif
  input  logic          En,
  output logic [CW-1:0] Round,
  output logic          First,
  output logic          Last,
  output logic          Busy,
  output logic          Done
);

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] ZERO    = '0;
  localparam logic [CW-1:0] NR_FIX  = CW'(NR);

  seq_state_t    state;
  logic [CW-1:0] round;
  logic          dir_lat;
  logic [CW-1:0] nr_lat;
  logic [CW-1:0] nr_sel;
  logic [CW-1:0] start_val;
  logic [CW-1:0] term_val;
  logic          at_term;

`ifdef AES_ROUND_SEQ_KEYLEN_EN
  aes_keylen_nr #(
    .CW (CW)
  ) u_keylen_nr (
    .keylen (KeyLen),
    .nr     (nr_sel)
  );
`else
  assign nr_sel = NR_FIX;
`endif

  // Start/terminal values depend only on latched block parameters.
  assign start_val = (dir_lat == AES_DIR_ENC) ? ZERO   : nr_lat;
  assign term_val  = (dir_lat == AES_DIR_ENC) ? nr_lat : ZERO;
  assign at_term   = (round == term_val);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= ST_IDLE;
      round   <= ZERO;
      dir_lat <= AES_DIR_ENC;
      nr_lat  <= NR_FIX;
    end else if (Clr) begin
      state <= ST_IDLE;
      round <= ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            dir_lat <= Dir;
            nr_lat  <= nr_sel;
            round   <= (Dir == AES_DIR_DEC) ? nr_sel : ZERO;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (En) begin
            if (at_term) begin
              state <= ST_DONE;
            end else if (dir_lat == AES_DIR_DEC) begin
              round <= round - ONE;
            end else begin
              round <= round + ONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          round <= ZERO;
        end
      endcase
    end
  end

  assign Round = round;
  assign Busy  = (state == ST_RUN);
  assign Done  = (state == ST_DONE);
  assign First = Busy && (round == start_val);
  assign Last  = Busy && at_term;

endmodule

`default_nettype wire
